// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential multi-digit BCD-to-binary converter. A packed DIGITS-digit BCD
//   word is accepted on an in_valid/in_ready handshake. It is then folded one
//   digit per clock, most significant digit first, as acc = acc*10 + digit.
//   The result is presented on an out_valid/out_ready handshake.
//
//   Optional feature (compile-time macro BCD2BIN_ERR_EN):
//     defined   - any nibble > 9 seen during conversion sets err with the result
//     undefined - no detection logic, err tied low
//   In both builds an invalid nibble contributes a digit value of 0.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   in_valid   in   1           bcd_in holds a word to convert
//   in_ready   out  1           controller can accept a word (IDLE)
//   bcd_in     in   4*DIGITS    packed BCD, digit DIGITS-1 in the MS nibble
//   out_valid  out  1           bin_out / err valid (DONE)
//   out_ready  in   1           consumer accepts the result
//   bin_out    out  BIN_W       binary result, 0 while out_valid is low
//   busy       out  1           conversion in progress (CONV)
//   err        out  1           invalid digit seen, valid with out_valid
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIGITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [4*DIGITS-1:0]  sreg;
  logic [BIN_W-1:0]     acc;
  logic [3:0]           nib;
  logic [3:0]           digit;
  logic [BIN_W-1:0]     acc_nxt;

  // Current digit is always the MS nibble; the word shifts up each cycle.
  assign nib = sreg[4*DIGITS-1 -: 4];

  // acc*10 + digit as two shifts and adds. Only the low BIN_W bits of the
  // product survive the final truncation, so computing directly at BIN_W
  // gives the same result as a wider sum that is truncated afterwards.
  always_comb begin
    digit   = (nib <= 4'd9) ? nib : 4'd0;
    acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);
  end

  // NOTE: state and datapath registers use non-blocking (<=) assignments
  // so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)          state_nxt = CONV;
      CONV:    if (cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Datapath. All of it is reset: a conversion cut short by rst must leave
  // no partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= bcd_in;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CONV: begin
          acc  <= acc_nxt;
          sreg <= sreg << 4;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD2BIN_ERR_EN
  logic err_flag;

  // Sticky per word: cleared on accept, set by any non-decimal nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      err_flag <= 1'b0;
    end else if (state == CONV && nib > 4'd9) begin
      err_flag <= 1'b1;
    end
  end

  assign err = (state == DONE) && err_flag;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);
  assign bin_out   = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14). Expected
//   results come from a reference model of the digit fold. They are queued
//   when a word is accepted and compared when the DUT hands a result over.
//   Expected err follows BCD2BIN_ERR_EN in the same way as in the DUT build.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
`ifdef BCD2BIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  bcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIN_W-1:0]     bin_out;
  logic                 busy;
  logic                 err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   accept_cyc;
  exp_t sb[$];
  exp_t mon_exp;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: decimal fold, non-decimal nibbles weigh 0.
  function automatic exp_t model(input logic [4*DIGITS-1:0] w);
    exp_t        r;
    int unsigned a;
    logic [3:0]  n;
    a     = 0;
    r.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      n = w[4*i +: 4];
      if (n > 4'd9) r.err = ERR_EN;
      a = a * 10 + ((n <= 4'd9) ? int'(n) : 0);
    end
    r.bin = BIN_W'(a);
    return r;
  endfunction

  // Scoreboard consumer: a result is handed over on a cycle with
  // out_valid && out_ready, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got bin_out=%0d err=%0b, expected no result",
                 bin_out, err);
      end else begin
        mon_exp = sb.pop_front();
        if (bin_out !== mon_exp.bin) begin
          errors++;
          $display("FAIL result_bin: got %0d, expected %0d", bin_out, mon_exp.bin);
        end
        checks++;
        if (err !== mon_exp.err) begin
          errors++;
          $display("FAIL result_err: got %0b, expected %0b", err, mon_exp.err);
        end
      end
    end
  end

  // Offer a word and hold in_valid until it is accepted. The task returns
  // 1 time unit after the accept edge with in_valid dropped.
  task automatic drive_word(input logic [4*DIGITS-1:0] w, input bit push_exp);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bcd_in   = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        got        = 1'b1;
        accept_cyc = cyc;
        if (push_exp) sb.push_back(model(w));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      in_valid = 1'b0;
      $display("FAIL accept_timeout: word %h, in_ready=%0b, expected 1", w, in_ready);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, bin_out, err} !== {1'b1, 1'b0, 1'b0, {BIN_W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b busy=%0b bin_out=%0d err=%0b, expected 1 0 0 0 0",
               in_ready, out_valid, busy, bin_out, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 16'h1234: latency DIGITS edges after accept, then in_ready returns.
  task automatic test_basic();
    out_ready = 1'b1;
    drive_word(16'h1234, 1'b1);
    for (int k = 1; k <= DIGITS; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_conv[%0d]: busy=%0b out_valid=%0b, expected 1 0", k, busy, out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_done: out_valid=%0b busy=%0b, expected 1 0", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== '0) begin
      errors++;
      $display("FAIL after_consume: in_ready=%0b out_valid=%0b bin_out=%0d, expected 1 0 0",
               in_ready, out_valid, bin_out);
    end
    wait_drain();
  endtask

  task automatic test_values();
    logic [4*DIGITS-1:0] words [4] = '{16'h9999, 16'h0000, 16'h12A4, 16'hF0B7};
    out_ready = 1'b1;
    foreach (words[i]) drive_word(words[i], 1'b1);
    wait_drain();
  endtask

  // Result held under back-pressure; in_valid during CONV ignored.
  task automatic test_hold();
    bit seen;
    out_ready = 1'b0;
    drive_word(16'h0321, 1'b1);
    bcd_in   = 16'h0777;
    in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_wait: out_valid=%0b, expected 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || bin_out !== 14'd321 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%0b bin_out=%0d in_ready=%0b, expected 1 321 0",
                 i, out_valid, bin_out, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b, expected 0 1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_word: out_valid=%0b busy=%0b, expected 0 0", out_valid, busy);
    end
    wait_drain();
  endtask

  // Async reset after two digits of 16'h5678 discards the word.
  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_word(16'h5678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || bin_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%0b busy=%0b in_ready=%0b bin_out=%0d, expected 0 0 1 0",
               out_valid, busy, in_ready, bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_word(16'h0042, 1'b1);
    wait_drain();
  endtask

  // in_valid held high: accepts exactly DIGITS+2 cycles apart.
  task automatic test_back_to_back();
    int  a1;
    int  a2;
    bit  got;
    out_ready = 1'b1;
    a1 = -1;
    a2 = -1;
    @(negedge clk);
    bcd_in   = 16'h0001;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        got = 1'b1;
        a1  = cyc;
        sb.push_back(model(16'h0001));
        @(posedge clk);
        #1;
        bcd_in = 16'h0010;
      end else @(negedge clk);
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        a2  = cyc;
        sb.push_back(model(16'h0010));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (a2 - a1 !== DIGITS + 2 || a1 < 0 || a2 < 0) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, expected %0d", a2 - a1, DIGITS + 2);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
